muldiv_sequencer: RTL

- Multi-cycle multiply/divide unit and HI/LO register owner for the pipelined MIPS datapath.
- Accepts MULT/MULTU/DIV/DIVU from the EX stage and runs one shift-add or restoring-divide iteration per cycle.
- Writes HI/LO on completion.
- Drives a pipeline stall while an MFHI/MFLO or a new mul/div instruction in ID/EX would see stale or busy state.

---
 rtl/muldiv_sequencer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative MULT/MULTU/DIV/DIVU engine and HI/LO owner.
// One shift-add or restoring-divide step per cycle, results land on FIX->DONE.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             ReadHiLo,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero,
  output logic             Stall,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    IDLE, PREP, RUN, FIX, DONE
  } state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic               isDiv;
  logic               isSigned;
  logic               resNeg;
  logic               dvdNeg;
  logic [WIDTH-1:0]   aReg;
  logic [WIDTH-1:0]   bReg;
  logic [WIDTH-1:0]   dsr;
  logic [2*WIDTH-1:0] prod;

  logic [WIDTH-1:0]   aMag;
  logic [WIDTH-1:0]   bMag;
  logic [WIDTH:0]     mulSum;
  logic [WIDTH:0]     trial;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] divNext;
  logic [2*WIDTH-1:0] prodNeg;
  logic [WIDTH-1:0]   fixHi;
  logic [WIDTH-1:0]   fixLo;
  logic               zeroDiv;

  assign Stall   = Busy & (ReadHiLo | Start);
  assign zeroDiv = Op[1] && (B == '0);

  always_comb begin
    aMag = aReg;
    bMag = bReg;
    if (isSigned && aReg[WIDTH-1]) aMag = -aReg;
    if (isSigned && bReg[WIDTH-1]) bMag = -bReg;
  end

  // WIDTH+1 bits keep the carry out of the partial-product add
  assign mulSum = {1'b0, prod[2*WIDTH-1:WIDTH]}
                + ({(WIDTH+1){prod[0]}} & {1'b0, dsr});

  // Trial includes the bit shifted out of rem, so large divisors compare right
  assign trial   = prod[2*WIDTH-1:WIDTH-1];
  assign diff    = trial - {1'b0, dsr};
  assign divNext = diff[WIDTH]
    ? {trial[WIDTH-1:0], prod[WIDTH-2:0], 1'b0}
    : {diff[WIDTH-1:0], prod[WIDTH-2:0], 1'b1};
  assign prodNeg = -prod;

  always_comb begin
    fixHi = prod[2*WIDTH-1:WIDTH];
    fixLo = prod[WIDTH-1:0];
    if (!isDiv) begin
      if (resNeg) {fixHi, fixLo} = prodNeg;
    end else begin
      if (resNeg) fixLo = -prod[WIDTH-1:0];
      if (dvdNeg) fixHi = -prod[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      isDiv     <= 1'b0;
      isSigned  <= 1'b0;
      resNeg    <= 1'b0;
      dvdNeg    <= 1'b0;
      aReg      <= '0;
      bReg      <= '0;
      dsr       <= '0;
      prod      <= '0;
      Hi        <= '0;
      Lo        <= '0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      DivByZero <= 1'b0;
    end else begin
      Done      <= 1'b0;
      DivByZero <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (Start && zeroDiv) begin
            state     <= DONE;
            Done      <= 1'b1;
            DivByZero <= 1'b1;
          end else if (Start) begin
            state    <= PREP;
            Busy     <= 1'b1;
            aReg     <= A;
            bReg     <= B;
            isDiv    <= Op[1];
            isSigned <= ~Op[0];
          end else begin
            state <= IDLE;
          end
        end
        PREP: begin
          dsr    <= bMag;
          prod   <= {{WIDTH{1'b0}}, aMag};
          cnt    <= CW'(WIDTH-1);
          resNeg <= isSigned & (aReg[WIDTH-1] ^ bReg[WIDTH-1]);
          dvdNeg <= isSigned & aReg[WIDTH-1];
          state  <= RUN;
        end
        RUN: begin
          prod <= isDiv ? divNext : {mulSum, prod[WIDTH-1:1]};
          cnt  <= cnt - 1'b1;
          if (cnt == '0) state <= FIX;
        end
        FIX: begin
          Hi    <= fixHi;
          Lo    <= fixLo;
          Busy  <= 1'b0;
          Done  <= 1'b1;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
